// File: rtl/tanh_interp_unit_pkg.sv
// Shared constants, FSM state type and the elaboration-time tanh table generator
// for the Q32.32 tanh interpolation unit.
package tanh_interp_unit_pkg;

  localparam int unsigned Q_W        = 64;
  localparam int unsigned Q_FRAC_W   = 32;
  localparam int unsigned STEP_SHIFT = 29;
  localparam int unsigned LUT_CENTER = 48;
  localparam int unsigned LUT_LAST   = 95;
  localparam int unsigned IDX_W      = 7;
  localparam int unsigned GEN_F      = 100;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    MAC  = 3'd3,
    HOLD = 3'd4
  } state_t;

  // tanh((k-48)/8) in Q32.32, magnitude truncated toward zero; evaluated only
  // with constant arguments, using e^(2x) = (e^0.25)^m at 100 guard fraction bits.
  function automatic logic [Q_W-1:0] tanh_entry(input int unsigned k);
    logic [255:0] one;
    logic [255:0] term;
    logic [255:0] e_q;
    logic [255:0] p;
    logic [255:0] num;
    logic [255:0] den;
    logic [255:0] quo;
    logic [Q_W-1:0] mag;
    int unsigned m;
    one  = 256'(1) << GEN_F;
    m    = (k >= LUT_CENTER) ? (k - LUT_CENTER) : (LUT_CENTER - k);
    e_q  = one;
    term = one;
    for (int unsigned n = 1; n <= 24; n++) begin
      term = term / 256'(4 * n);
      e_q  = e_q + term;
    end
    p = one;
    for (int unsigned i = 0; i < m; i++) begin
      p = (p * e_q) >> GEN_F;
    end
    num = (p - one) << Q_FRAC_W;
    den = p + one;
    quo = num / den;
    mag = quo[Q_W-1:0];
    return (k < LUT_CENTER) ? (-mag) : mag;
  endfunction

endpackage

// File: rtl/tanh_32_32_lut.sv
// Combinational Q32.32 tanh table, x = -6.0 .. +5.875 in steps of 0.125.
module tanh_32_32_lut
  import tanh_interp_unit_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [Q_W-1:0]   y
);

  logic [Q_W-1:0] rom [LUT_LAST+1];

  for (genvar k = 0; k <= int'(LUT_LAST); k++) begin : g_rom
    localparam logic [Q_W-1:0] ENTRY = tanh_entry(k);
    assign rom[k] = ENTRY;
  end

  always_comb begin
    y = '0;
    if (idx <= IDX_W'(LUT_LAST)) begin
      y = rom[idx];
    end
  end

endmodule

// File: rtl/tanh_interp_unit.sv
// Q32.32 tanh front-end: index/fraction split, one or two LUT reads through a
// single shared table, linear interpolation, valid/ready output hold.
module tanh_interp_unit
  import tanh_interp_unit_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Q_W-1:0] x_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Q_W-1:0] y_out
);

  localparam int unsigned PROD_W = Q_W + 2 + STEP_SHIFT + 1;
  localparam logic signed [Q_W-1:0] RAW_MIN = -$signed(Q_W'(LUT_CENTER));
  localparam logic signed [Q_W-1:0] RAW_MAX = $signed(Q_W'(LUT_LAST - LUT_CENTER));

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [STEP_SHIFT-1:0] frac_q, frac_d;
  logic                  sat_q, sat_d;
  logic [Q_W-1:0]        y0_q, y0_d;
  logic [Q_W-1:0]        y1_q, y1_d;
  logic [Q_W-1:0]        y_q, y_d;
  logic                  out_valid_q, out_valid_d;

  logic signed [Q_W-1:0]    raw;
  logic [IDX_W-1:0]         idx_in;
  logic                     sat_in;
  logic signed [Q_W+1:0]    diff;
  logic signed [PROD_W-1:0] prod;
  logic [Q_W-1:0]           mac_y;
  logic [IDX_W-1:0]         lut_idx;
  logic [Q_W-1:0]           lut_y;

  tanh_32_32_lut u_lut (
    .idx (lut_idx),
    .y   (lut_y)
  );

  always_comb begin
    raw    = $signed(x_in) >>> STEP_SHIFT;
    idx_in = '0;
    sat_in = 1'b0;
    if (raw < RAW_MIN) begin
      sat_in = 1'b1;
    end else if (raw >= RAW_MAX) begin
      idx_in = IDX_W'(LUT_LAST);
      sat_in = 1'b1;
    end else begin
      idx_in = IDX_W'(raw + $signed(Q_W'(LUT_CENTER)));
    end
  end

  // Difference kept two bits wider so the signed product never wraps.
  always_comb begin
    diff  = $signed({y1_q[Q_W-1], y1_q[Q_W-1], y1_q}) - $signed({y0_q[Q_W-1], y0_q[Q_W-1], y0_q});
    prod  = diff * $signed({1'b0, frac_q});
    mac_y = y0_q + Q_W'(prod >>> STEP_SHIFT);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frac_d      = frac_q;
    sat_d       = sat_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    lut_idx     = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          idx_d   = idx_in;
          frac_d  = x_in[STEP_SHIFT-1:0];
          sat_d   = sat_in;
          state_d = RD0;
        end
      end
      RD0: begin
        lut_idx = idx_q;
        y0_d    = lut_y;
        if (sat_q || (frac_q == '0)) begin
          y_d         = lut_y;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          state_d = RD1;
        end
      end
      RD1: begin
        lut_idx = idx_q + IDX_W'(1);
        y1_d    = lut_y;
        state_d = MAC;
      end
      MAC: begin
        y_d         = mac_y;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      frac_q      <= '0;
      sat_q       <= 1'b0;
      y0_q        <= '0;
      y1_q        <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frac_q      <= frac_d;
      sat_q       <= sat_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign y_out     = y_q;

endmodule

// File: tb/tb_tanh_interp_unit.sv
// Directed self-checking bench for tanh_interp_unit.
module tb_tanh_interp_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] x_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] y_out;

  int checks;
  int errors;

  localparam logic [63:0] Y_P0125  = 64'h0000_0000_1FD5_992B;
  localparam logic [63:0] Y_P00625 = 64'h0000_0000_0FEA_CC95;
  localparam logic [63:0] Y_N00625 = 64'hFFFF_FFFF_F015_336A;
  localparam logic [63:0] Y_NEG6   = 64'hFFFF_FFFF_0000_CE2B;
  localparam logic [63:0] Y_POS5875 = 64'h0000_0000_FFFE_F747;

  tanh_interp_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic run_txn(input logic [63:0] x, output int lat, output logic busy_ok,
                         output logic [63:0] y);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    x_in     = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_in     = '0;
    lat      = 1;
    busy_ok  = 1'b1;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready !== 1'b0) busy_ok = 1'b0;
    y = y_out;
  endtask

  task automatic release_txn();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (y_out !== 64'h0) begin
      errors++; $display("FAIL reset_y_out: got %h expected 0", y_out);
    end
  endtask

  task automatic test_exact();
    logic [63:0] xs [2];
    logic [63:0] ys [2];
    int          lat;
    logic        busy_ok;
    logic [63:0] y;
    xs[0] = 64'h0;                  ys[0] = 64'h0;
    xs[1] = 64'h0000_0000_2000_0000; ys[1] = Y_P0125;
    for (int unsigned i = 0; i < 2; i++) begin
      run_txn(xs[i], lat, busy_ok, y);
      checks++;
      if (y !== ys[i]) begin
        errors++; $display("FAIL exact_y[%0d]: got %h expected %h", i, y, ys[i]);
      end
      checks++;
      if (lat != 2) begin
        errors++; $display("FAIL exact_latency[%0d]: got %0d expected 2", i, lat);
      end
      checks++;
      if (busy_ok !== 1'b1) begin
        errors++; $display("FAIL exact_busy[%0d]: in_ready got 1 expected 0", i);
      end
      release_txn();
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_interp();
    logic [63:0] xs [2];
    logic [63:0] ys [2];
    int          lat;
    logic        busy_ok;
    logic [63:0] y;
    xs[0] = 64'h0000_0000_1000_0000; ys[0] = Y_P00625;
    xs[1] = 64'hFFFF_FFFF_F000_0000; ys[1] = Y_N00625;
    for (int unsigned i = 0; i < 2; i++) begin
      run_txn(xs[i], lat, busy_ok, y);
      checks++;
      if (y !== ys[i]) begin
        errors++; $display("FAIL interp_y[%0d]: got %h expected %h", i, y, ys[i]);
      end
      checks++;
      if (lat != 4) begin
        errors++; $display("FAIL interp_latency[%0d]: got %0d expected 4", i, lat);
      end
      checks++;
      if (busy_ok !== 1'b1) begin
        errors++; $display("FAIL interp_busy[%0d]: in_ready got 1 expected 0", i);
      end
      release_txn();
    end
  endtask

  task automatic test_saturation();
    logic [63:0] xs [2];
    logic [63:0] ys [2];
    int          lat;
    logic        busy_ok;
    logic [63:0] y;
    xs[0] = 64'hFFFF_FFF6_0000_0000; ys[0] = Y_NEG6;
    xs[1] = 64'h0000_0007_0000_0000; ys[1] = Y_POS5875;
    for (int unsigned i = 0; i < 2; i++) begin
      run_txn(xs[i], lat, busy_ok, y);
      checks++;
      if (y !== ys[i]) begin
        errors++; $display("FAIL sat_y[%0d]: got %h expected %h", i, y, ys[i]);
      end
      checks++;
      if (lat != 2) begin
        errors++; $display("FAIL sat_latency[%0d]: got %0d expected 2", i, lat);
      end
      release_txn();
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic        busy_ok;
    logic [63:0] y;
    out_ready = 1'b0;
    run_txn(64'h0000_0000_2000_0000, lat, busy_ok, y);
    checks++;
    if (y !== Y_P0125) begin
      errors++; $display("FAIL bp_y: got %h expected %h", y, Y_P0125);
    end
    for (int unsigned i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      x_in     = (i == 2) ? 64'h0000_0007_0000_0000 : 64'h0;
      @(posedge clk); #1;
      checks++;
      if (y_out !== Y_P0125 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got y=%h ov=%b ir=%b expected y=%h ov=1 ir=0",
                 i, y_out, out_valid, in_ready, Y_P0125);
      end
    end
    in_valid = 1'b0;
    x_in     = '0;
    release_txn();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_exit: got ir=%b ov=%b expected ir=1 ov=0", in_ready, out_valid);
    end
    for (int unsigned i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_ignored[%0d]: got ir=%b ov=%b expected ir=1 ov=0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic        busy_ok;
    logic [63:0] y;
    out_ready = 1'b0;
    run_txn(64'h0000_0000_2000_0000, lat, busy_ok, y);
    in_valid  = 1'b1;
    x_in      = 64'h0000_0000_1000_0000;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_exit_no_accept: got ir=%b ov=%b expected ir=1 ov=0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_in     = '0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: in_ready got %b expected 0", in_ready);
    end
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL b2b_latency: got %0d expected 4", lat);
    end
    checks++;
    if (y_out !== Y_P00625) begin
      errors++; $display("FAIL b2b_y: got %h expected %h", y_out, Y_P00625);
    end
    release_txn();
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic        busy_ok;
    logic [63:0] y;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x_in      = 64'h0000_0000_1000_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_in     = '0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || y_out !== 64'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got ov=%b y=%h ir=%b expected ov=0 y=0 ir=1",
               out_valid, y_out, in_ready);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL mid_reset_dropped[%0d]: out_valid got 1 expected 0", i);
      end
    end
    run_txn(64'h0000_0000_2000_0000, lat, busy_ok, y);
    checks++;
    if (y !== Y_P0125) begin
      errors++; $display("FAIL mid_reset_fresh_y: got %h expected %h", y, Y_P0125);
    end
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL mid_reset_fresh_latency: got %0d expected 2", lat);
    end
    release_txn();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_exact();
    test_interp();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
